// File: rtl/dfc_stream_pkg.sv
// Shared lane/vector types and serializer state encoding for the VectorSum sink path.
package dfc_stream_pkg;

    localparam int unsigned WIDTH      = 16;
    localparam int unsigned LANES      = 4;
    localparam int unsigned LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef logic [WIDTH-1:0] lane_t;
    typedef lane_t [LANES-1:0] vec_t;

    typedef enum logic {
        IDLE,
        EMIT
    } ser_state_e;

endpackage

// File: rtl/dfc_valid_delay.sv
// Fixed-length 1-bit shift register that tracks issued tokens through the kernel latency.
module dfc_valid_delay #(
    parameter int unsigned LATENCY = 60
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    output logic valid_o
);

    logic [LATENCY-1:0] sr_q;
    logic [LATENCY-1:0] sr_d;

    if (LATENCY == 1) begin : g_single
        assign sr_d = valid_i;
    end else begin : g_chain
        assign sr_d = {sr_q[LATENCY-2:0], valid_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign valid_o = sr_q[LATENCY-1];

endmodule

// File: rtl/vector_sum_sink_serializer.sv
// Captures VectorSum kernel results into a credit-bounded vector FIFO and streams each
// vector out lane by lane with a last flag.
module vector_sum_sink_serializer
    import dfc_stream_pkg::*;
#(
    parameter int unsigned LATENCY = 60,
    parameter int unsigned DEPTH   = 4
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  in_valid,
    output logic  in_ready,
    input  vec_t  sink_lane,
    output lane_t out_data,
    output logic  out_valid,
    input  logic  out_ready,
    output logic  out_last,
    output logic  overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0]      PTR_MAX   = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [LANE_IDX_W-1:0] LANE_LAST = LANE_IDX_W'(LANES - 1);

    vec_t                  fifo_q [DEPTH];
    vec_t                  fifo_d [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      credit_q, credit_d;
    logic                  overflow_q, overflow_d;
    ser_state_e            state_q, state_d;
    logic [LANE_IDX_W-1:0] lane_idx_q, lane_idx_d;

    logic issue;
    logic push;
    logic pop;

    assign in_ready = (credit_q < CNT_DEPTH);
    assign overflow = overflow_q;
    assign issue    = in_valid & in_ready;

    dfc_valid_delay #(
        .LATENCY(LATENCY)
    ) u_token_delay (
        .clk_i  (clock),
        .rst_ni (reset),
        .valid_i(issue),
        .valid_o(push)
    );

    // Kernel lanes are only meaningful when a tracked token emerges.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = sink_lane;
            wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!push && pop) begin
            count_d = count_q - CNT_ONE;
        end

        // Credits cover tokens in flight plus queued vectors, so the FIFO cannot overrun.
        credit_d = credit_q;
        if (issue && !pop) begin
            credit_d = credit_q + CNT_ONE;
        end else if (!issue && pop) begin
            credit_d = credit_q - CNT_ONE;
        end

        overflow_d = overflow_q | (in_valid & ~in_ready);
    end

    always_comb begin
        state_d    = state_q;
        lane_idx_d = lane_idx_q;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (push || (count_q != '0)) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = fifo_q[rd_ptr_q][lane_idx_q];
                out_last  = (lane_idx_q == LANE_LAST);
                if (out_ready) begin
                    if (lane_idx_q == LANE_LAST) begin
                        pop        = 1'b1;
                        lane_idx_d = '0;
                        // Stay in EMIT when another vector is queued or arriving now.
                        if ((count_q == CNT_ONE) && !push) begin
                            state_d = IDLE;
                        end
                    end else begin
                        lane_idx_d = lane_idx_q + LANE_IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= '0;
            overflow_q <= 1'b0;
            state_q    <= IDLE;
            lane_idx_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            lane_idx_q <= lane_idx_d;
        end
    end

endmodule

// File: tb/tb_vector_sum_sink_serializer.sv
// Directed and randomized bench for vector_sum_sink_serializer against a queue-based
// model of issue tokens, captured vectors, credits and the beat stream.
module tb_vector_sum_sink_serializer;
    import dfc_stream_pkg::*;

    localparam int LAT = 60;
    localparam int DEP = 4;

    logic  clock = 1'b0;
    logic  reset = 1'b1;
    logic  in_valid = 1'b0;
    logic  in_ready;
    vec_t  sink_lane = '0;
    lane_t out_data;
    logic  out_valid;
    logic  out_ready = 1'b1;
    logic  out_last;
    logic  overflow;

    always #5 clock = ~clock;

    vector_sum_sink_serializer #(
        .LATENCY(LAT),
        .DEPTH  (DEP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sink_lane(sink_lane),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .overflow (overflow)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model state
    int          cap_q[$];     // cycles at which an issued vector's lanes are captured
    logic [63:0] exp_q[$];     // captured vectors awaiting emission
    int          exp_rdy[$];   // first cycle each captured vector may be on the output
    int          lane_pos   = 0;
    int          outstanding = 0;
    logic        ovf_m      = 1'b0;

    // Observed beat log and issue count
    logic [15:0] log_d[$];
    int          log_c[$];
    logic        log_l[$];
    int          n_acc_obs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_log();
        log_d.delete();
        log_c.delete();
        log_l.delete();
    endtask

    task automatic clear_model();
        cap_q.delete();
        exp_q.delete();
        exp_rdy.delete();
        lane_pos    = 0;
        outstanding = 0;
        ovf_m       = 1'b0;
    endtask

    // Called at a negedge with inputs already applied; checks, advances one clock.
    task automatic tick();
        logic        e_valid;
        logic        e_ready;
        logic        acc;
        logic        hs;
        logic [15:0] e_data;
        e_valid = (exp_q.size() > 0) && (exp_rdy[0] <= cyc);
        e_ready = (outstanding < DEP);
        chk("in_ready", 32'(in_ready), 32'(e_ready));
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("overflow", 32'(overflow), 32'(ovf_m));
        if (e_valid) begin
            e_data = exp_q[0][lane_pos*16 +: 16];
            chk("out_data", 32'(out_data), 32'(e_data));
            chk("out_last", 32'(out_last), 32'(lane_pos == LANES - 1));
        end else begin
            chk("out_last_idle", 32'(out_last), 32'd0);
        end
        if (out_valid && out_ready) begin
            log_d.push_back(out_data);
            log_c.push_back(cyc);
            log_l.push_back(out_last);
        end
        if (in_valid && in_ready) n_acc_obs++;

        acc = in_valid & e_ready;
        hs  = e_valid & out_ready;
        if (in_valid && !e_ready) ovf_m = 1'b1;
        if (acc) cap_q.push_back(cyc + LAT);
        if (cap_q.size() > 0 && cap_q[0] == cyc) begin
            exp_q.push_back(64'(sink_lane));
            exp_rdy.push_back(cyc + 1);
            void'(cap_q.pop_front());
        end
        if (hs) begin
            if (lane_pos == LANES - 1) begin
                void'(exp_q.pop_front());
                void'(exp_rdy.pop_front());
                lane_pos = 0;
                outstanding--;
            end else begin
                lane_pos++;
            end
        end
        if (acc) outstanding++;

        @(posedge clock);
        @(negedge clock);
        cyc++;
        sink_lane = vec_t'({$urandom, $urandom});
    endtask

    task automatic hold_reset(input int n);
        reset = 1'b0;
        repeat (n) begin
            @(negedge clock);
            cyc++;
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_overflow", 32'(overflow), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
        end
        reset = 1'b1;
        clear_model();
    endtask

    logic [15:0] single_exp [4];
    int          t0;

    initial begin
        single_exp[0] = 16'h0011;
        single_exp[1] = 16'h0022;
        single_exp[2] = 16'h0033;
        single_exp[3] = 16'h0044;

        #1;
        hold_reset(3);

        // Idle after reset: no output for 100 cycles
        clear_log();
        repeat (100) begin
            out_ready = 1'($urandom);
            tick();
        end
        chk("idle_beats", 32'(log_d.size()), 32'd0);

        // Single vector with fixed latency
        out_ready = 1'b1;
        clear_log();
        t0 = cyc;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (LAT - 1) tick();
        sink_lane = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
        tick();
        repeat (10) tick();
        chk("single_count", 32'(log_d.size()), 32'd4);
        if (log_d.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("single_data", 32'(log_d[i]), 32'(single_exp[i]));
                chk("single_cycle", 32'(log_c[i]), 32'(t0 + LAT + 1 + i));
                chk("single_last", 32'(log_l[i]), 32'(i == 3));
            end
        end

        // Back-pressure: credits cap issue at DEPTH, overflow sticks
        out_ready = 1'b0;
        n_acc_obs = 0;
        in_valid  = 1'b1;
        repeat (10) tick();
        chk("bp_accepted", 32'(n_acc_obs), 32'(DEP));
        chk("bp_overflow", 32'(overflow), 32'd1);
        in_valid = 1'b0;
        repeat (LAT + 5) tick();
        clear_log();
        out_ready = 1'b1;
        repeat (20) tick();
        chk("bp_beats", 32'(log_d.size()), 32'(DEP * LANES));

        // Stall hold: out_ready toggling every cycle
        clear_log();
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        repeat (LAT + 30) begin
            out_ready = cyc[0];
            tick();
        end
        chk("stall_beats", 32'(log_d.size()), 32'd8);

        // Capture coincides with last-beat pop while credits are full
        out_ready = 1'b1;
        clear_log();
        for (int k = 0; k < 7; k++) begin
            in_valid = (k == 0 || k == 4 || k == 5 || k == 6);
            tick();
        end
        in_valid = 1'b0;
        repeat (LAT + 20) tick();
        chk("sim_beats", 32'(log_d.size()), 32'd16);
        if (log_c.size() == 16) begin
            chk("sim_no_bubble", 32'(log_c[4] - log_c[3]), 32'd1);
        end

        // Randomized traffic
        repeat (1500) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (LAT + DEP * LANES + 10) tick();
        chk("drain_empty", 32'(exp_q.size() + cap_q.size()), 32'd0);

        // Reset mid-flight drops in-flight tokens
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        repeat (20) tick();
        hold_reset(1);
        clear_log();
        repeat (LAT + 40) tick();
        chk("mid_rst_beats", 32'(log_d.size()), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
